// File: rtl/full_adder.sv
// 1-bit full adder cell: the only arithmetic element of the serial adder.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller.
// Computes {o_carry_out, o_sum} = A + B + cin one bit per cycle, LSB first, through a single
// full_adder cell. A start in IDLE latches the operands. RUN takes WIDTH cycles. A one-cycle DONE
// state pulses o_done. The visible result registers are written only on the final RUN edge, so
// they keep the last completed result until the next operation finishes.
module serial_adder_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_operand_a,
  input  logic [WIDTH-1:0] i_operand_b,
  input  logic             i_carry_in,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_carry_out
);

  localparam int unsigned     CntW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] part_q, part_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic fa_sum;
  logic fa_cout;

  full_adder u_full_adder (
    .a    (a_q[cnt_q]),
    .b    (b_q[cnt_q]),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // Next-state logic: operand latch in IDLE, one bit per cycle in RUN, single-cycle DONE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    part_d  = part_q;
    sum_d   = sum_q;
    cout_d  = cout_q;

    case (state_q)
      StIdle: begin
        if (i_start) begin
          a_d     = i_operand_a;
          b_d     = i_operand_b;
          carry_d = i_carry_in;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        part_d[cnt_q] = fa_sum;
        carry_d       = fa_cout;
        if (cnt_q == LastCnt) begin
          // Last bit: publish the full result; the counter stops here rather than wrapping.
          sum_d   = part_d;
          cout_d  = fa_cout;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers; reset clears everything including any partial result.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      part_q  <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      part_q  <= part_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign o_busy      = (state_q == StRun);
  assign o_done      = (state_q == StDone);
  assign o_sum       = sum_q;
  assign o_carry_out = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl at WIDTH=8 and WIDTH=2.
// Drivers push A+B+cin into a queue. Negedge monitors pop on o_done, check latency and verify that
// the result holds while idle.
module tb_serial_adder_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       st8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       cin8 = 1'b0;
  logic       busy8, done8, cout8;
  logic [7:0] sum8;

  logic       st2 = 1'b0;
  logic [1:0] a2 = '0, b2 = '0;
  logic       cin2 = 1'b0;
  logic       busy2, done2, cout2;
  logic [1:0] sum2;

  int checks   = 0;
  int failures = 0;

  logic [8:0] q8[$];
  logic [2:0] q2[$];
  logic [8:0] held8 = '0;
  logic [2:0] held2 = '0;
  int         busy_n8 = 0;
  int         busy_n2 = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start     (st8),
    .i_operand_a (a8),
    .i_operand_b (b8),
    .i_carry_in  (cin8),
    .o_busy      (busy8),
    .o_done      (done8),
    .o_sum       (sum8),
    .o_carry_out (cout8)
  );

  serial_adder_ctrl #(.WIDTH(2)) dut2 (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start     (st2),
    .i_operand_a (a2),
    .i_operand_b (b2),
    .i_carry_in  (cin2),
    .o_busy      (busy2),
    .o_done      (done2),
    .o_sum       (sum2),
    .o_carry_out (cout2)
  );

  // Monitor for the 8-bit instance.
  always @(negedge clk) begin
    logic [8:0] e;
    if (rst) begin
      busy_n8 = 0;
      held8   = '0;
    end else begin
      if (busy8) busy_n8++;
      if (done8) begin
        checks++;
        if (q8.size() == 0) begin
          failures++;
          $display("FAIL w8_unexpected_done got sum=%h cout=%b, required no done", sum8, cout8);
        end else begin
          e = q8.pop_front();
          if ({cout8, sum8} !== e) begin
            failures++;
            $display("FAIL w8_result got %h required %h", {cout8, sum8}, e);
          end
          held8 = e;
        end
        checks++;
        if (busy_n8 != 8 || busy8) begin
          failures++;
          $display("FAIL w8_latency got busy_cycles=%0d busy=%b required 8 and 0", busy_n8, busy8);
        end
        busy_n8 = 0;
      end else if (!busy8) begin
        checks++;
        if ({cout8, sum8} !== held8) begin
          failures++;
          $display("FAIL w8_hold got %h required %h", {cout8, sum8}, held8);
        end
      end
    end
  end

  // Monitor for the 2-bit instance.
  always @(negedge clk) begin
    logic [2:0] e;
    if (rst) begin
      busy_n2 = 0;
      held2   = '0;
    end else begin
      if (busy2) busy_n2++;
      if (done2) begin
        checks++;
        if (q2.size() == 0) begin
          failures++;
          $display("FAIL w2_unexpected_done got sum=%h cout=%b, required no done", sum2, cout2);
        end else begin
          e = q2.pop_front();
          if ({cout2, sum2} !== e) begin
            failures++;
            $display("FAIL w2_result got %h required %h", {cout2, sum2}, e);
          end
          held2 = e;
        end
        checks++;
        if (busy_n2 != 2 || busy2) begin
          failures++;
          $display("FAIL w2_latency got busy_cycles=%0d busy=%b required 2 and 0", busy_n2, busy2);
        end
        busy_n2 = 0;
      end else if (!busy2) begin
        checks++;
        if ({cout2, sum2} !== held2) begin
          failures++;
          $display("FAIL w2_hold got %h required %h", {cout2, sum2}, held2);
        end
      end
    end
  end

  // Called just after a rising edge with the DUT idle; leaves the DUT in its first RUN cycle.
  task automatic go8(input logic [7:0] a, input logic [7:0] b, input logic c);
    a8 = a; b8 = b; cin8 = c; st8 = 1'b1;
    q8.push_back({1'b0, a} + {1'b0, b} + {8'd0, c});
    @(posedge clk); #1;
    st8 = 1'b0;
  endtask

  // Waits for o_done (optionally scrambling inputs meanwhile), then steps into IDLE.
  task automatic wait_done8(input bit noise);
    int n = 0;
    while (!done8 && n < 30) begin
      if (noise) begin
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom); st8 = 1'($urandom);
      end
      @(posedge clk); #1;
      n++;
    end
    st8 = 1'b0;
    checks++;
    if (!done8) begin
      failures++;
      $display("FAIL w8_timeout got done=%b required 1 within 30 cycles", done8);
    end
    @(posedge clk); #1;
  endtask

  task automatic go2(input logic [1:0] a, input logic [1:0] b, input logic c);
    a2 = a; b2 = b; cin2 = c; st2 = 1'b1;
    q2.push_back({1'b0, a} + {1'b0, b} + {2'd0, c});
    @(posedge clk); #1;
    st2 = 1'b0;
  endtask

  task automatic wait_done2(input bit noise);
    int n = 0;
    while (!done2 && n < 20) begin
      if (noise) begin
        a2 = 2'($urandom); b2 = 2'($urandom); cin2 = 1'($urandom); st2 = 1'($urandom);
      end
      @(posedge clk); #1;
      n++;
    end
    st2 = 1'b0;
    checks++;
    if (!done2) begin
      failures++;
      $display("FAIL w2_timeout got done=%b required 1 within 20 cycles", done2);
    end
    @(posedge clk); #1;
  endtask

  task automatic check_idle8(input string name);
    checks++;
    if (busy8 !== 1'b0 || done8 !== 1'b0 || sum8 !== 8'h00 || cout8 !== 1'b0) begin
      failures++;
      $display("FAIL %s got busy=%b done=%b sum=%h cout=%b required 0 0 00 0",
               name, busy8, done8, sum8, cout8);
    end
  endtask

  initial begin
    // Reset with a start request pending: reset must win.
    st8 = 1'b1; a8 = 8'h55; b8 = 8'h55;
    repeat (3) @(posedge clk);
    #1;
    check_idle8("reset_state");
    st8 = 1'b0;
    rst = 1'b0;

    // Fixed vectors.
    go8(8'h00, 8'h00, 1'b0); wait_done8(1'b0);
    go8(8'hFF, 8'h01, 1'b0); wait_done8(1'b0);
    go8(8'h3C, 8'h42, 1'b0); wait_done8(1'b0);

    // Operands change right after acceptance.
    go8(8'hA5, 8'h5A, 1'b1);
    a8 = 8'hFF; b8 = 8'hFF;
    wait_done8(1'b0);

    // Start held high through RUN with a different A: one done, result 8'h11.
    go8(8'h10, 8'h01, 1'b0);
    a8 = 8'hFF; st8 = 1'b1;
    wait_done8(1'b0);
    checks++;
    if (busy8 !== 1'b0) begin
      failures++;
      $display("FAIL w8_start_ignored got busy=%b required 0", busy8);
    end

    // Reset during RUN: abort, no done, partial result cleared.
    go8(8'hC3, 8'h7E, 1'b1);
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    q8.delete();
    @(posedge clk); #1;
    check_idle8("w8_mid_run_reset");
    rst = 1'b0;
    go8(8'h01, 8'h01, 1'b0); wait_done8(1'b0);

    // Random back-to-back operations with input noise while busy.
    for (int i = 0; i < 24; i++) begin
      go8(8'($urandom), 8'($urandom), 1'($urandom));
      wait_done8(1'b1);
    end

    // Exhaustive 2-bit sweep.
    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++)
        for (int c = 0; c < 2; c++) begin
          go2(2'(a), 2'(b), 1'(c));
          wait_done2(1'b1);
        end

    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (q8.size() != 0 || q2.size() != 0) begin
      failures++;
      $display("FAIL queues_drained got q8=%0d q2=%0d required 0 0", q8.size(), q2.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL global_timeout got running required finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
